// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready handshake and saturating counters.
// Optional macro HAMMING_SYNDROME_OUT_EN adds syndrome_out = {P,S} of the word currently on data_out.
module hamming_secded_decoder_pipe #(
    parameter int PARITY_BITS = 4,
    parameter int CODE_W      = 2**PARITY_BITS,
    parameter int DATA_W      = 2**PARITY_BITS - PARITY_BITS - 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CODE_W-1:0]    c_h,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 error,
    output logic                 error_incorrectable,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 clr_counts,
    output logic [CNT_W-1:0]     corr_count,
`ifdef HAMMING_SYNDROME_OUT_EN
    output logic [PARITY_BITS:0] syndrome_out,
`endif
    output logic [CNT_W-1:0]     uncorr_count
);

    logic [PARITY_BITS-1:0] w_syn;
    logic                   w_par;
    logic                   w_s2Adv;
    logic                   w_s1Adv;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_single;
    logic                   w_double;
    logic                   w_err;
    logic [CODE_W-2:0]      w_flipMask;
    logic [DATA_W-1:0]      w_dataRaw;
    logic [DATA_W-1:0]      w_dataFix;

    logic                   r_s1Valid;
    logic [CODE_W-2:0]      r_s1Code;
    logic [PARITY_BITS-1:0] r_s1Syn;
    logic                   r_s1Par;

    logic                   r_s2Valid;
    logic [DATA_W-1:0]      r_data;
    logic                   r_err;
    logic                   r_errInc;
    logic [CNT_W-1:0]       r_corr;
    logic [CNT_W-1:0]       r_uncorr;

    // Syndrome bit j covers every Hamming position whose index has bit j set.
    for (genvar j = 0; j < PARITY_BITS; j++) begin : g_syn
        logic [CODE_W-2:0] w_mask;
        for (genvar i = 0; i < CODE_W-1; i++) begin : g_bit
            assign w_mask[i] = ((((i + 1) >> j) & 1) == 1) ? c_h[i] : 1'b0;
        end
        assign w_syn[j] = ^w_mask;
    end

    assign w_par    = (^c_h[CODE_W-2:0]) ^ c_h[CODE_W-1];
    assign w_s2Adv  = ~r_s2Valid | out_ready;
    assign w_s1Adv  = ~r_s1Valid | w_s2Adv;
    assign in_ready = enable & w_s1Adv;
    assign w_accept = in_valid & in_ready;
    assign w_load   = r_s1Valid & w_s2Adv;

    assign w_single   = r_s1Par & (r_s1Syn != '0);
    assign w_double   = ~r_s1Par & (r_s1Syn != '0);
    assign w_err      = r_s1Par | (r_s1Syn != '0);
    assign w_flipMask = w_single ? ((CODE_W-1)'(1) << (r_s1Syn - 1'b1)) : '0;

    // Payload bit k is the k-th non-power-of-two position; positions up to p hold clog2(p+1) parity bits.
    for (genvar p = 1; p < CODE_W; p++) begin : g_extract
        if ((p & (p - 1)) != 0) begin : g_dataPos
            assign w_dataRaw[p - $clog2(p + 1) - 1] = r_s1Code[p-1];
            assign w_dataFix[p - $clog2(p + 1) - 1] = r_s1Code[p-1] ^ w_flipMask[p-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Code  <= '0;
            r_s1Syn   <= '0;
            r_s1Par   <= 1'b0;
        end else if (w_s1Adv) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Code <= c_h[CODE_W-2:0];
                r_s1Syn  <= w_syn;
                r_s1Par  <= w_par;
            end
        end
    end

    // Double errors pass the raw extraction through; everything else is corrected first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_errInc  <= 1'b0;
        end else if (w_s2Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_data   <= w_double ? w_dataRaw : w_dataFix;
                r_err    <= w_err;
                r_errInc <= w_double;
            end
        end
    end

    // Any P=1 word (including a flipped overall parity bit) counts as corrected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (clr_counts) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (w_load) begin
            if (r_s1Par && (r_corr != '1)) begin
                r_corr <= r_corr + 1'b1;
            end
            if (w_double && (r_uncorr != '1)) begin
                r_uncorr <= r_uncorr + 1'b1;
            end
        end
    end

`ifdef HAMMING_SYNDROME_OUT_EN
    logic [PARITY_BITS:0] r_synOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_synOut <= '0;
        end else if (w_s2Adv && r_s1Valid) begin
            r_synOut <= {r_s1Par, r_s1Syn};
        end
    end

    assign syndrome_out = r_synOut;
`else
    // Syndrome and overall parity stay internal to the correction logic.
`endif

    assign out_valid           = r_s2Valid;
    assign data_out            = r_data;
    assign error               = r_err;
    assign error_incorrectable = r_errInc;
    assign corr_count          = r_corr;
    assign uncorr_count        = r_uncorr;

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Self-checking bench for hamming_secded_decoder_pipe: encodes random payloads, injects 0-2 bit errors and
// checks every delivered word against a queue of expectations; a CNT_W=2 twin checks counter saturation.
module tb_hamming_secded_decoder_pipe;

    typedef struct packed {
        logic [10:0] d;
        logic        e;
        logic        ei;
    } exp_t;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b1;
    logic        in_valid   = 1'b0;
    logic        out_ready  = 1'b1;
    logic        clr_counts = 1'b0;
    logic [15:0] c_h        = '0;

    logic        in_ready, error, error_incorrectable, out_valid;
    logic [10:0] data_out;
    logic [15:0] corr_count, uncorr_count;

    logic        in_ready2, error2, errInc2, out_valid2;
    logic [10:0] data2;
    logic [1:0]  corr2, uncorr2;
`ifdef HAMMING_SYNDROME_OUT_EN
    logic [4:0]  syn1, syn2;
`endif

    exp_t q[$];
    exp_t cmpE;
    int   checks      = 0;
    int   passes      = 0;
    int   modelCorr   = 0;
    int   modelUncorr = 0;
    bit   randBp      = 1'b0;
    bit   holdPrev    = 1'b0;
    logic [12:0] heldVal = '0;

    hamming_secded_decoder_pipe dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .c_h(c_h), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .error(error),
        .error_incorrectable(error_incorrectable), .out_valid(out_valid),
        .out_ready(out_ready), .clr_counts(clr_counts), .corr_count(corr_count),
`ifdef HAMMING_SYNDROME_OUT_EN
        .syndrome_out(syn1),
`endif
        .uncorr_count(uncorr_count)
    );

    hamming_secded_decoder_pipe #(.CNT_W(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .enable(enable), .c_h(c_h), .in_valid(in_valid),
        .in_ready(in_ready2), .data_out(data2), .error(error2),
        .error_incorrectable(errInc2), .out_valid(out_valid2),
        .out_ready(out_ready), .clr_counts(clr_counts), .corr_count(corr2),
`ifdef HAMMING_SYNDROME_OUT_EN
        .syndrome_out(syn2),
`endif
        .uncorr_count(uncorr2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Reference encoder: payload into non-power-of-two positions, then even parity per group.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic        par;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            par = 1'b0;
            for (int p = 1; p < 16; p++) if (((p >> j) & 1) == 1) par = par ^ c[p-1];
            c[(1 << j) - 1] = par;
        end
        c[15] = ^c[14:0];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return d;
    endfunction

    // flips < 0 picks 0, 1 or 2 bit errors at random.
    task automatic genWord(input int flips, output logic [15:0] code, output exp_t e);
        logic [10:0] d;
        int          n, b1, b2;
        d    = 11'($urandom);
        code = encode(d);
        n    = (flips < 0) ? int'($urandom_range(0, 2)) : flips;
        b1   = $urandom_range(0, 15);
        b2   = (b1 + int'($urandom_range(1, 15))) % 16;
        if (n >= 1) code = code ^ (16'(1) << b1);
        if (n == 2) code = code ^ (16'(1) << b2);
        e.d  = (n == 2) ? extract(code) : d;
        e.e  = (n != 0);
        e.ei = (n == 2);
    endtask

    task automatic applyStimulus(input logic [15:0] code, input exp_t e, input int budget, output bit ok);
        ok       = 1'b0;
        c_h      = code;
        in_valid = 1'b1;
        for (int n = 0; n < budget && !ok; n++) begin
            if (randBp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                q.push_back(e);
                if (e.ei) modelUncorr++;
                else if (e.e) modelCorr++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic sendChecked(input logic [15:0] code, input exp_t e);
        bit ok;
        applyStimulus(code, e, 64, ok);
        checkOutput("accept", ok, 1);
    endtask

    task automatic drain();
        randBp    = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 30 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drainEmpty", q.size(), 0);
    endtask

    task automatic checkCounts();
        checkOutput("corrCount", corr_count, modelCorr);
        checkOutput("uncorrCount", uncorr_count, modelUncorr);
        checkOutput("corrCountSat", corr2, (modelCorr > 3) ? 3 : modelCorr);
        checkOutput("uncorrCountSat", uncorr2, (modelUncorr > 3) ? 3 : modelUncorr);
    endtask

    // Scoreboard: every delivered word must match the oldest expectation; held words must not move.
    always @(negedge clk) begin
        if (rst_n) begin
            if (holdPrev) begin
                checkOutput("holdValid", out_valid, 1);
                checkOutput("holdData", {data_out, error, error_incorrectable}, heldVal);
            end
            if (out_valid && out_ready) begin
                checkOutput("queueNonEmpty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    cmpE = q.pop_front();
                    checkOutput("data", data_out, cmpE.d);
                    checkOutput("error", error, cmpE.e);
                    checkOutput("errorIncorrectable", error_incorrectable, cmpE.ei);
                end
            end
            holdPrev = out_valid && !out_ready;
            heldVal  = {data_out, error, error_incorrectable};
        end else begin
            holdPrev = 1'b0;
        end
    end

    initial begin
        logic [15:0] code;
        exp_t        e;
        bit          ok;
        int          acceptedCount;

        #8;
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstData", data_out, 0);
        checkOutput("rstError", {error, error_incorrectable}, 0);
        checkOutput("rstCounts", {corr_count, uncorr_count}, 0);
        #14 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstInReady", in_ready, 1);

        checkOutput("modelEncodeOnes", encode(11'h7FF), 16'hFFFF);
        checkOutput("modelEncodeOne", encode(11'h001), 16'h8007);
        checkOutput("modelExtract", extract(16'h0010), 11'h002);

        // Directed words with literal expectations, including the two-register latency.
        sendChecked(16'h0000, '{d: 11'h000, e: 1'b0, ei: 1'b0});
        checkOutput("latency1", out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("latency2", out_valid, 1);
        sendChecked(16'hFFFF, '{d: 11'h7FF, e: 1'b0, ei: 1'b0});
        sendChecked(16'hFFEF, '{d: 11'h7FF, e: 1'b1, ei: 1'b0});
        sendChecked(16'h0003, '{d: 11'h000, e: 1'b1, ei: 1'b1});
        sendChecked(16'h8000, '{d: 11'h000, e: 1'b1, ei: 1'b0});
        drain();
        checkOutput("corrLiteral", corr_count, 2);
        checkOutput("uncorrLiteral", uncorr_count, 1);
        checkCounts();

        clr_counts = 1'b1;
        @(posedge clk);
        #1;
        clr_counts  = 1'b0;
        modelCorr   = 0;
        modelUncorr = 0;
        checkCounts();

        // Saturation, then a clear coinciding with an increment.
        for (int i = 0; i < 5; i++) begin
            genWord(1, code, e);
            sendChecked(code, e);
        end
        drain();
        checkCounts();
        genWord(1, code, e);
        sendChecked(code, e);
        clr_counts  = 1'b1;
        modelCorr   = 0;
        modelUncorr = 0;
        @(posedge clk);
        #1;
        clr_counts = 1'b0;
        drain();
        checkCounts();

        // Random traffic with random backpressure and idle gaps.
        randBp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            genWord(-1, code, e);
            sendChecked(code, e);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        checkCounts();

        // Backpressure: only two words fit while the consumer stalls.
        out_ready     = 1'b0;
        acceptedCount = 0;
        for (int i = 0; i < 3; i++) begin
            genWord(-1, code, e);
            applyStimulus(code, e, 3, ok);
            if (ok) acceptedCount++;
        end
        checkOutput("bpAccepted", acceptedCount, 2);
        checkOutput("bpInReady", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            genWord(-1, code, e);
            sendChecked(code, e);
        end
        drain();
        checkCounts();

        // enable=0 blocks new words while the pipe still drains.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            genWord(-1, code, e);
            sendChecked(code, e);
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("enableGate", in_ready, 0);
        end
        checkOutput("enableDrained", q.size(), 0);
        enable = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset with two words in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            genWord(1, code, e);
            sendChecked(code, e);
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncOutValid", out_valid, 0);
        checkOutput("asyncData", data_out, 0);
        checkOutput("asyncCounts", {corr_count, uncorr_count}, 0);
        checkOutput("asyncCountsSmall", {corr2, uncorr2}, 0);
        q.delete();
        modelCorr   = 0;
        modelUncorr = 0;
        #10 rst_n   = 1'b1;
        out_ready   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("noStaleWord", out_valid, 0);
        end
        checkCounts();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder_pipe.md
Name: hamming_secded_decoder_pipe

Overview:
Parametrised, pipelined SECDED (extended Hamming) decoder. It is the streaming successor to the team's combinational 16/11 decoder. It accepts one codeword per cycle over a valid/ready handshake, corrects single-bit errors, flags double-bit errors, and keeps saturating error-statistics counters. It sits between the channel/memory read path and the consumer of decoded data.

Parameters:
- PARITY_BITS, 4: Hamming parity bit count r; r >= 3.
- CODE_W, 2**PARITY_BITS: codeword width, including the overall parity bit (derived; not to be overridden).
- DATA_W, 2**PARITY_BITS-PARITY_BITS-1: payload width (derived; 11 at default).
- CNT_W, 16: width of each statistics counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- enable, in, 1: accept gate; 0 forces in_ready=0, in-flight words still drain.
- c_h, in, CODE_W: received codeword.
- in_valid, in, 1: c_h valid.
- in_ready, out, 1: decoder can accept c_h this cycle.
- data_out, out, DATA_W: decoded/corrected payload.
- error, out, 1: any error detected in this word.
- error_incorrectable, out, 1: double error detected; payload not corrected.
- out_valid, out, 1: data_out/status valid.
- out_ready, in, 1: consumer accepts output.
- clr_counts, in, 1: synchronous clear of both counters.
- corr_count, out, CNT_W: number of single errors seen (saturating).
- uncorr_count, out, CNT_W: number of double errors seen (saturating).

Behaviour:
- Codeword layout:
  - c_h bit i (0..CODE_W-2) holds Hamming position i+1.
  - Parity bits sit at power-of-two positions.
  - Bit CODE_W-1 is the overall parity: even parity over bits 0..CODE_W-2.
  - data_out[k] = the k-th non-power-of-two position in ascending order (default: c_h bits 2,4,5,6,8..14).
- Syndrome S (PARITY_BITS wide): bit j = XOR of all c_h bits i (0..CODE_W-2) with ((i+1)>>j)&1. It is XOR, not an arithmetic sum.
- P = XOR(c_h[0..CODE_W-2]) != c_h[CODE_W-1].
- Classification:
  - S=0, P=0: clean; error=0, error_incorrectable=0.
  - S=0, P=1: overall parity bit error; error=1, error_incorrectable=0, data unchanged; counts as corrected.
  - S!=0, P=1: single error; flip c_h bit S-1, then extract; error=1, error_incorrectable=0.
  - S!=0, P=0: double error; error=1, error_incorrectable=1, data_out = raw uncorrected extraction.
- Pipeline has 2 register stages:
  - Stage 1 captures c_h, S, P.
  - Stage 2 captures corrected data and status.
  - Latency is 2 cycles from the in_valid&in_ready edge to out_valid with no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs on a rising edge with valid&ready high.
  - Stage 2 advances when empty or out_ready=1.
  - Stage 1 advances when empty or stage 2 advances.
  - in_ready = enable & (stage 1 empty | stage 2 advances).
  - out_valid and data/status hold stable while out_valid=1 and out_ready=0.
  - in_ready does not depend on in_valid.
- Counters:
  - Increment by 1 when a word enters stage 2 with the corresponding class.
  - Saturate at 2**CNT_W-1.
  - If clr_counts and an increment coincide, clear wins, giving 0.
- Reset (async assert, sync release): stages empty, out_valid=0, data_out=0, error=0, error_incorrectable=0, corr_count=0, uncorr_count=0. A reset asserted mid-operation discards in-flight words.
- No X propagation: when a stage is empty, its registers hold their last value and out_valid=0.

Optional Feature:
- Macro: HAMMING_SYNDROME_OUT_EN.
- Defined: adds output port syndrome_out, width PARITY_BITS+1, holding {P,S} of the word on data_out. It is registered with stage 2, resets to 0, and holds under backpressure.
- Undefined: port and its registers absent; all other behaviour identical.

Test Plan:
- Default params, c_h=16'h0000, out_ready=1 -> 2 cycles later out_valid=1, data_out=11'h000, error=0, error_incorrectable=0, counters unchanged.
- c_h=16'hFFFF -> data_out=11'h7FF, error=0. Then 16'hFFFF with bit 4 flipped -> data_out=11'h7FF, error=1, error_incorrectable=0, corr_count=1.
- c_h=16'h0000 with bits 0 and 1 flipped -> error=1, error_incorrectable=1, data_out=11'h000, uncorr_count=1. With bit 15 only flipped -> error=1, error_incorrectable=0, data_out=11'h000, corr_count increments.
- Backpressure: out_ready=0, 4 back-to-back valid words -> exactly 2 accepted, in_ready=0 afterwards. Release out_ready -> all 4 words emerge in order, none lost or duplicated.
- CNT_W=2, 5 single-error words -> corr_count stops at 3. clr_counts asserted on the same cycle as a 6th single-error word -> corr_count=0.
- rst_n pulsed low mid-stream with 2 words in flight -> out_valid=0 and counters 0 immediately (asynchronously), no stale word output after release. enable=0 -> in_ready=0 while the pipe drains.
